// File: rtl/fk_pkg.sv
//==============================================================================
// fk_pkg - shared types, CORDIC constants and helpers for the fk_engine slice
// rev 1.0
//==============================================================================
`default_nettype none

package fk_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      COR1  = 3'd2,
      COR2  = 3'd3,
      MUL   = 3'd4,
      ADD   = 3'd5,
      OUT   = 3'd6
   } fk_state_t;

   // CORDIC gain K = prod(1/sqrt(1+2^-2i)) in Q30
   localparam int CORDIC_K_Q30 = 652032874;

   function automatic int gain_init(input int frac_w);
      return (CORDIC_K_Q30 + (1 << (29 - frac_w))) >>> (30 - frac_w);
   endfunction

   // atan(2^-i)/pi in Q30, rescaled so that pi = 2^(angle_w+1)
   function automatic int atan_lut(input int i, input int angle_w);
      int v;
      int sh;
      case (i)
         0:       v = 268435456;
         1:       v = 158466703;
         2:       v = 83729454;
         3:       v = 42502389;
         4:       v = 21333666;
         5:       v = 10677232;
         6:       v = 5339919;
         7:       v = 2670122;
         8:       v = 1335082;
         9:       v = 667543;
         10:      v = 333772;
         11:      v = 166886;
         12:      v = 83443;
         13:      v = 41722;
         14:      v = 20861;
         15:      v = 10430;
         default: v = 341782638 >>> i;
      endcase
      sh = 29 - angle_w;
      return (v + (1 << (sh - 1))) >>> sh;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fk_cordic.sv
//==============================================================================
// fk_cordic - iterative rotation-mode CORDIC, cos/sin of a signed binary angle
// rev 1.0
//==============================================================================
`default_nettype none

module fk_cordic
   import fk_pkg::*;
#(
   parameter int ANGLE_W      = 13,
   parameter int FRAC_W       = 16,
   parameter int CORDIC_ITERS = 14
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic signed [ANGLE_W-1:0] angle,
   output logic                      done,
   output logic signed [FRAC_W+1:0]  cos_o,
   output logic signed [FRAC_W+1:0]  sin_o
);

   localparam int ZW = ANGLE_W + 2;
   localparam int TW = FRAC_W + 2;
   localparam int CW = $clog2(CORDIC_ITERS + 1);
   localparam logic signed [ZW-1:0] HALF_PI = ZW'(1 << (ZW - 2));
   localparam logic signed [ZW-1:0] NEG_PI  = {1'b1, {(ZW-1){1'b0}}};
   localparam logic signed [TW-1:0] K0      = TW'(gain_init(FRAC_W));

   logic signed [TW-1:0] x_q, y_q, x0_d, y0_d, x_d, y_d;
   logic signed [ZW-1:0] z_q, z0_d, z_d, za;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q, done_q;

   always_comb begin
      za   = {angle, 2'b00};
      x0_d = K0;
      y0_d = '0;
      z0_d = za;
      // Fold into [-pi/2, pi/2] by starting from the +/-y axis; -pi is treated as +pi
      if (za == NEG_PI) begin
         x0_d = '0;
         y0_d = K0;
         z0_d = HALF_PI;
      end else if (za > HALF_PI) begin
         x0_d = '0;
         y0_d = K0;
         z0_d = za - HALF_PI;
      end else if (za < -HALF_PI) begin
         x0_d = '0;
         y0_d = -K0;
         z0_d = za + HALF_PI;
      end

      if (!z_q[ZW-1]) begin
         x_d = x_q - (y_q >>> cnt_q);
         y_d = y_q + (x_q >>> cnt_q);
         z_d = z_q - ZW'(atan_lut(int'(cnt_q), ANGLE_W));
      end else begin
         x_d = x_q + (y_q >>> cnt_q);
         y_d = y_q - (x_q >>> cnt_q);
         z_d = z_q + ZW'(atan_lut(int'(cnt_q), ANGLE_W));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            x_q    <= x0_d;
            y_q    <= y0_d;
            z_q    <= z0_d;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(CORDIC_ITERS - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done  = done_q;
   assign cos_o = x_q;
   assign sin_o = y_q;

endmodule

`default_nettype wire

// File: rtl/fk_engine.sv
//==============================================================================
// fk_engine - two-link SCARA forward kinematics on one shared CORDIC.
// FK_ROUND_EN: round-half-up on the final >>FRAC_W scaling (floor otherwise). rev 1.0
//==============================================================================
`default_nettype none

module fk_engine
   import fk_pkg::*;
#(
   parameter int ANGLE_W      = 13,
   parameter int LEN_W        = 16,
   parameter int OUT_W        = 14,
   parameter int FRAC_W       = 16,
   parameter int CORDIC_ITERS = 14
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [ANGLE_W-1:0] theta1,
   input  logic signed [ANGLE_W-1:0] theta2,
   input  logic [LEN_W-1:0]          l1,
   input  logic [LEN_W-1:0]          l2,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [OUT_W-1:0]   x,
   output logic signed [OUT_W-1:0]   y,
   output logic                      sat
);

   localparam int TW = FRAC_W + 2;
   localparam int PW = LEN_W + FRAC_W + 2;
`ifdef FK_ROUND_EN
   localparam logic signed [63:0] RND = 64'sd1 <<< (FRAC_W - 1);
`else
   localparam logic signed [63:0] RND = 64'sd0;
`endif

   fk_state_t                 state_q;
   logic signed [ANGLE_W-1:0] th1_q, th2_q, ths_q, cor_angle;
   logic [LEN_W-1:0]          l1_q, l2_q;
   logic signed [TW-1:0]      c1_q, s1_q, cs_q, ss_q, cor_cos, cor_sin;
   logic signed [PW-1:0]      px1_q, px2_q, py1_q, py2_q;
   logic signed [PW-1:0]      m_l1, m_l2, m_t1, m_t2, prod1, prod2;
   logic signed [63:0]        sx, sy, xs, ys;
   logic signed [OUT_W-1:0]   x_q, y_q, x_d, y_d;
   logic                      mul_ph_q, in_ready_q, out_valid_q, sat_q, sat_d;
   logic                      cor_start, cor_done;

   fk_cordic #(
      .ANGLE_W      (ANGLE_W),
      .FRAC_W       (FRAC_W),
      .CORDIC_ITERS (CORDIC_ITERS)
   ) u_cordic (
      .clk   (clk),
      .reset (reset),
      .start (cor_start),
      .angle (cor_angle),
      .done  (cor_done),
      .cos_o (cor_cos),
      .sin_o (cor_sin)
   );

   always_comb begin
      cor_start = (state_q == LATCH) || ((state_q == COR1) && cor_done);
      cor_angle = (state_q == LATCH) ? th1_q : ths_q;

      // Two multipliers: cos products in the first MUL cycle, sin products in the second
      m_l1  = signed'(PW'(l1_q));
      m_l2  = signed'(PW'(l2_q));
      m_t1  = mul_ph_q ? PW'(s1_q) : PW'(c1_q);
      m_t2  = mul_ph_q ? PW'(ss_q) : PW'(cs_q);
      prod1 = m_l1 * m_t1;
      prod2 = m_l2 * m_t2;

      sx    = 64'(px1_q) + 64'(px2_q) + RND;
      sy    = 64'(py1_q) + 64'(py2_q) + RND;
      xs    = sx >>> FRAC_W;
      ys    = sy >>> FRAC_W;
      x_d   = OUT_W'(saturate(xs, OUT_W));
      y_d   = OUT_W'(saturate(ys, OUT_W));
      sat_d = (saturate(xs, OUT_W) != xs) || (saturate(ys, OUT_W) != ys);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         sat_q       <= 1'b0;
         mul_ph_q    <= 1'b0;
         th1_q       <= '0;
         th2_q       <= '0;
         ths_q       <= '0;
         l1_q        <= '0;
         l2_q        <= '0;
         c1_q        <= '0;
         s1_q        <= '0;
         cs_q        <= '0;
         ss_q        <= '0;
         px1_q       <= '0;
         px2_q       <= '0;
         py1_q       <= '0;
         py2_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  th1_q      <= theta1;
                  th2_q      <= theta2;
                  l1_q       <= l1;
                  l2_q       <= l2;
                  in_ready_q <= 1'b0;
                  state_q    <= LATCH;
               end
            end
            LATCH: begin
               ths_q   <= th1_q + th2_q;
               state_q <= COR1;
            end
            COR1: begin
               if (cor_done) begin
                  c1_q    <= cor_cos;
                  s1_q    <= cor_sin;
                  state_q <= COR2;
               end
            end
            COR2: begin
               if (cor_done) begin
                  cs_q     <= cor_cos;
                  ss_q     <= cor_sin;
                  mul_ph_q <= 1'b0;
                  state_q  <= MUL;
               end
            end
            MUL: begin
               if (!mul_ph_q) begin
                  px1_q    <= prod1;
                  px2_q    <= prod2;
                  mul_ph_q <= 1'b1;
               end else begin
                  py1_q    <= prod1;
                  py2_q    <= prod2;
                  mul_ph_q <= 1'b0;
                  state_q  <= ADD;
               end
            end
            ADD: begin
               x_q         <= x_d;
               y_q         <= y_d;
               sat_q       <= sat_d;
               out_valid_q <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign x         = x_q;
   assign y         = y_q;
   assign sat       = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_fk_engine.sv
//==============================================================================
// tb_fk_engine - directed self-checking bench for fk_engine (binary angle: 4096 = pi)
// rev 1.0
//==============================================================================
`default_nettype none

module tb_fk_engine;

   localparam int ANGLE_W = 13;
   localparam int LEN_W   = 16;
   localparam int OUT_W   = 14;
   localparam int LAT     = 35;
   localparam int PERIOD  = 36;

   // l1=100, l2=50; expected x/y = 100*cos/sin(t1) + 50*cos/sin(t1+t2), rounded
   localparam int NA = 7;
   localparam int A_T1 [NA] = '{2048,  2048, 4095, -4096, 1024, -3072,  3072};
   localparam int A_T2 [NA] = '{   0,  2048,    2,     0,    0,  1024, -1024};
   localparam int A_X  [NA] = '{   0,   -50, -150,  -150,  106,   -71,   -71};
   localparam int A_Y  [NA] = '{ 150,   100,    0,     0,  106,  -121,   121};

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic                      in_valid = 1'b0;
   logic                      out_ready = 1'b0;
   logic                      in_ready, out_valid, sat;
   logic signed [ANGLE_W-1:0] theta1 = '0;
   logic signed [ANGLE_W-1:0] theta2 = '0;
   logic [LEN_W-1:0]          l1 = '0;
   logic [LEN_W-1:0]          l2 = '0;
   logic signed [OUT_W-1:0]   x, y;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;

   fk_engine dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .theta1    (theta1),
      .theta2    (theta2),
      .l1        (l1),
      .l2        (l2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x         (x),
      .y         (y),
      .sat       (sat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one request; lat = cycles from accept to out_valid, -1 on timeout
   task automatic issue(input int t1, input int t2, input int a, input int b, output int lat);
      int w;
      lat = -1;
      w = 0;
      while (!in_ready && w < 100) begin
         tick();
         w++;
      end
      if (!in_ready) return;
      theta1   = ANGLE_W'(t1);
      theta2   = ANGLE_W'(t2);
      l1       = LEN_W'(a);
      l2       = LEN_W'(b);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      acc_cyc  = cyc;
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      checks++;
      if ({in_ready, out_valid, sat} !== 3'b100) begin
         errors++;
         $display("FAIL reset_flags got in_ready/out_valid/sat=%b want 100", {in_ready, out_valid, sat});
      end
      checks++;
      if (x !== '0 || y !== '0) begin
         errors++;
         $display("FAIL reset_xy got x=%0d y=%0d want 0 0", x, y);
      end
   endtask

   task automatic test_latency();
      int lat;
      issue(0, 0, 100, 50, lat);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL latency got %0d want %0d", lat, LAT);
      end
      checks++;
      if (int'(x) > 152 || int'(x) < 148 || int'(y) > 2 || int'(y) < -2 || sat !== 1'b0) begin
         errors++;
         $display("FAIL zero_angle got x=%0d y=%0d sat=%b want 150 0 0 (+-2)", x, y, sat);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_angles();
      int lat;
      for (int i = 0; i < NA; i++) begin
         issue(A_T1[i], A_T2[i], 100, 50, lat);
         checks++;
         if (lat !== LAT) begin
            errors++;
            $display("FAIL angle%0d_latency got %0d want %0d", i, lat, LAT);
         end
         checks++;
         if (int'(x) > A_X[i] + 2 || int'(x) < A_X[i] - 2) begin
            errors++;
            $display("FAIL angle%0d_x got %0d want %0d+-2", i, x, A_X[i]);
         end
         checks++;
         if (int'(y) > A_Y[i] + 2 || int'(y) < A_Y[i] - 2) begin
            errors++;
            $display("FAIL angle%0d_y got %0d want %0d+-2", i, y, A_Y[i]);
         end
         checks++;
         if (sat !== 1'b0) begin
            errors++;
            $display("FAIL angle%0d_sat got %b want 0", i, sat);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_saturation();
      int lat;
      issue(0, 0, 65535, 65535, lat);
      checks++;
      if (x !== 14'sd8191 || sat !== 1'b1 || lat !== LAT) begin
         errors++;
         $display("FAIL sat_pos got x=%0d sat=%b lat=%0d want 8191 1 %0d", x, sat, lat, LAT);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      issue(4095, 0, 65535, 65535, lat);
      checks++;
      if (x !== -14'sd8192 || sat !== 1'b1) begin
         errors++;
         $display("FAIL sat_neg got x=%0d sat=%b want -8192 1", x, sat);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int lat;
      logic signed [OUT_W-1:0] hx, hy;
      issue(1024, 0, 100, 50, lat);
      hx = x;
      hy = y;
      checks++;
      if (int'(hx) > 108 || int'(hx) < 104 || int'(hy) > 108 || int'(hy) < 104) begin
         errors++;
         $display("FAIL bp_value got x=%0d y=%0d want 106 106 (+-2)", hx, hy);
      end
      repeat (10) begin
         tick();
         checks++;
         if (x !== hx || y !== hy || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got x=%0d y=%0d ov=%b ir=%b want %0d %0d 1 0",
                     x, y, out_valid, in_ready, hx, hy);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got ov=%b ir=%b want 0 1", out_valid, in_ready);
      end
      repeat (3) tick();
      checks++;
      if (x !== hx || y !== hy || state_idle_ready() !== 1'b1) begin
         errors++;
         $display("FAIL idle_hold got x=%0d y=%0d ir=%b want %0d %0d 1", x, y, in_ready, hx, hy);
      end
   endtask

   function automatic logic state_idle_ready();
      return in_ready & ~out_valid;
   endfunction

   task automatic test_back_to_back();
      int lat;
      int first_acc;
      out_ready = 1'b1;
      issue(0, 0, 100, 50, lat);
      first_acc = acc_cyc;
      checks++;
      if (int'(x) > 152 || int'(x) < 148) begin
         errors++;
         $display("FAIL b2b_first_x got %0d want 150+-2", x);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready got ov=%b ir=%b want 0 1", out_valid, in_ready);
      end
      issue(1024, 0, 100, 50, lat);
      checks++;
      if (acc_cyc - first_acc !== PERIOD) begin
         errors++;
         $display("FAIL b2b_period got %0d want %0d", acc_cyc - first_acc, PERIOD);
      end
      checks++;
      if (lat !== LAT || int'(y) > 108 || int'(y) < 104) begin
         errors++;
         $display("FAIL b2b_second got lat=%0d y=%0d want %0d 106+-2", lat, y, LAT);
      end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midflight();
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 100) begin
         tick();
         w++;
      end
      theta1   = ANGLE_W'(0);
      theta2   = ANGLE_W'(0);
      l1       = LEN_W'(100);
      l2       = LEN_W'(50);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (19) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || x !== '0 || y !== '0 || sat !== 1'b0) begin
         errors++;
         $display("FAIL midflight_reset got ov=%b ir=%b x=%0d y=%0d sat=%b want 0 1 0 0 0",
                  out_valid, in_ready, x, y, sat);
      end
      reset = 1'b0;
      issue(3072, -1024, 100, 50, lat);
      checks++;
      if (lat !== LAT || int'(x) > -69 || int'(x) < -73 || int'(y) > 123 || int'(y) < 119) begin
         errors++;
         $display("FAIL after_reset got lat=%0d x=%0d y=%0d want %0d -71 121 (+-2)", lat, x, y, LAT);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_angles();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
